dmac_write: RTL and testbench

Write path of the AXI DMA controller, the counterpart of the read path. It accepts one transfer command at a time, which the read path issues after fetching source data. It splits the command into AXI4 write bursts, issues them on AW, streams the read path's data beats onto W, and collects B responses. When the whole command has completed, it reports a single done/error status.

---
 rtl/dmac_write_pkg.sv | 19 +
 rtl/dmac_write_if.sv | 45 ++++
 rtl/dmac_write_burst_calc.sv | 30 +++
 rtl/dmac_write.sv | 188 ++++++++++++++++++
 tb/tb_dmac_write.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmac_write_pkg.sv
// AXI4 write-channel constants shared by the DMA write path and its burst splitter.
package dmac_write_pkg;

    localparam int BURST_BITS = 2;
    localparam int LEN_BITS   = 8;
    localparam int SIZE_BITS  = 3;

    localparam logic [BURST_BITS-1:0] BURST_FIXED = 2'b00;
    localparam logic [BURST_BITS-1:0] BURST_INCR  = 2'b01;
    localparam logic [BURST_BITS-1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int BOUNDARY_4K = 4096;

endpackage

// File: rtl/dmac_write_if.sv
// AXI4 write address / data / response channels; master drives AW, W and bready.
interface dmac_write_if #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32
);
    import dmac_write_pkg::*;

    localparam int STRB_WD = DATA_WD / 8;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WD-1:0]    awaddr;
    logic [LEN_BITS-1:0]   awlen;
    logic [SIZE_BITS-1:0]  awsize;
    logic [BURST_BITS-1:0] awburst;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_WD-1:0]    wdata;
    logic [STRB_WD-1:0]    wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic [1:0]            bresp;
    logic                  bready;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );

endinterface

// File: rtl/dmac_write_burst_calc.sv
// Beats in the next burst: min(remaining, MAX_BURST_LEN, beats to next 4 KiB page for INCR).
module dmac_write_burst_calc
    import dmac_write_pkg::*;
#(
    parameter int ADDR_WD       = 32,
    parameter int MAX_BURST_LEN = 16,
    parameter int BEATS_WD      = $clog2(MAX_BURST_LEN) + 1
) (
    input  logic [ADDR_WD-1:0]    addr,
    input  logic [ADDR_WD-1:0]    remaining,
    input  logic [SIZE_BITS-1:0]  size,
    input  logic [BURST_BITS-1:0] burst,
    output logic [BEATS_WD-1:0]   beats
);

    logic [12:0]        to_bound;
    logic [ADDR_WD-1:0] lim;

    always_comb begin
        // address is size-aligned, so the page remainder is never below one beat
        to_bound = (13'(BOUNDARY_4K) - {1'b0, addr[11:0]}) >> size;
        lim      = ADDR_WD'(MAX_BURST_LEN);
        if (remaining < lim)
            lim = remaining;
        if ((burst == BURST_INCR) && (ADDR_WD'(to_bound) < lim))
            lim = ADDR_WD'(to_bound);
        beats = lim[BEATS_WD-1:0];
    end

endmodule

// File: rtl/dmac_write.sv
// DMA write path: splits one command into AXI4 write bursts and reports a single done/error.
module dmac_write
    import dmac_write_pkg::*;
#(
    parameter int ADDR_WD       = 32,
    parameter int DATA_WD       = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WD-1:0]    cmd_dst_addr,
    input  logic [BURST_BITS-1:0] cmd_burst,
    input  logic [ADDR_WD-1:0]    cmd_len,
    input  logic [SIZE_BITS-1:0]  cmd_size,

    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    input  logic [DATA_WD-1:0]    data_in,
    input  logic                  data_in_last,

    output logic                  done_valid,
    output logic                  done_err,

    dmac_write_if.master          m_axi
);

    localparam int STRB_WD  = DATA_WD / 8;
    localparam int BEATS_WD = $clog2(MAX_BURST_LEN) + 1;

    // state  | meaning
    // IDLE   | waiting for a command
    // AW     | presenting one burst address
    // W      | streaming that burst's beats
    // B      | waiting for the burst response
    // DONE   | one-cycle completion pulse
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WD-1:0]    addr_q, addr_d;
    logic [BURST_BITS-1:0] burst_q, burst_d;
    logic [SIZE_BITS-1:0]  size_q, size_d;
    logic [ADDR_WD-1:0]    remaining_q, remaining_d;
    logic [BEATS_WD-1:0]   beats_q, beats_d;
    logic [BEATS_WD-1:0]   cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic [ADDR_WD-1:0]    next_addr;
    logic [ADDR_WD-1:0]    next_rem;
    logic [ADDR_WD-1:0]    calc_addr;
    logic [ADDR_WD-1:0]    calc_rem;
    logic [SIZE_BITS-1:0]  calc_size;
    logic [BURST_BITS-1:0] calc_burst;
    logic [BEATS_WD-1:0]   calc_beats;
    logic                  w_hs;
    logic                  last_cmd_beat;

    assign next_addr = (burst_q == BURST_INCR) ? addr_q + (ADDR_WD'(beats_q) << size_q) : addr_q;
    assign next_rem  = remaining_q - ADDR_WD'(beats_q);

    // one splitter serves both the first burst (from the command) and every following one
    always_comb begin
        calc_addr  = next_addr;
        calc_rem   = next_rem;
        calc_size  = size_q;
        calc_burst = burst_q;
        if (state_q == S_IDLE) begin
            calc_addr  = cmd_dst_addr;
            calc_rem   = cmd_len;
            calc_size  = cmd_size;
            calc_burst = cmd_burst;
        end
    end

    dmac_write_burst_calc #(
        .ADDR_WD       (ADDR_WD),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .BEATS_WD      (BEATS_WD)
    ) u_burst_calc (
        .addr      (calc_addr),
        .remaining (calc_rem),
        .size      (calc_size),
        .burst     (calc_burst),
        .beats     (calc_beats)
    );

    assign w_hs          = m_axi.wvalid && m_axi.wready;
    assign last_cmd_beat = (cnt_q == BEATS_WD'(1)) && (remaining_q == ADDR_WD'(beats_q));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        size_d      = size_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_dst_addr;
                    burst_d     = cmd_burst;
                    size_d      = cmd_size;
                    remaining_d = cmd_len;
                    err_d       = 1'b0;
                    beats_d     = calc_beats;
                    state_d     = S_AW;
                end
            end
            S_AW: begin
                if (m_axi.awready) begin
                    cnt_d   = beats_q;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (w_hs) begin
                    cnt_d = cnt_q - BEATS_WD'(1);
                    if (data_in_last != last_cmd_beat)
                        err_d = 1'b1;
                    if (cnt_q == BEATS_WD'(1))
                        state_d = S_B;
                end
            end
            S_B: begin
                if (m_axi.bvalid) begin
                    err_d       = err_q | m_axi.bresp[1];
                    remaining_d = next_rem;
                    addr_d      = next_addr;
                    if (next_rem == '0) begin
                        state_d = S_DONE;
                    end else begin
                        beats_d = calc_beats;
                        state_d = S_AW;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            burst_q     <= '0;
            size_q      <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            burst_q     <= burst_d;
            size_q      <= size_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready     = (state_q == S_IDLE) && !rst;
    assign data_in_ready = (state_q == S_W) && m_axi.wready;
    assign done_valid    = (state_q == S_DONE);
    assign done_err      = (state_q == S_DONE) && err_q;

    assign m_axi.awvalid = (state_q == S_AW);
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = LEN_BITS'(beats_q - BEATS_WD'(1));
    assign m_axi.awsize  = size_q;
    assign m_axi.awburst = burst_q;
    assign m_axi.wvalid  = (state_q == S_W) && data_in_valid;
    assign m_axi.wdata   = data_in;
    assign m_axi.wstrb   = {STRB_WD{1'b1}};
    assign m_axi.wlast   = (state_q == S_W) && (cnt_q == BEATS_WD'(1));
    assign m_axi.bready  = (state_q == S_B);

endmodule

// File: tb/tb_dmac_write.sv
// Randomized bench for dmac_write against a burst-list / beat-order reference model.
module tb_dmac_write;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_dst_addr;
    logic [1:0]  cmd_burst;
    logic [31:0] cmd_len;
    logic [2:0]  cmd_size;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [31:0] data_in;
    logic        data_in_last;
    logic        done_valid;
    logic        done_err;

    dmac_write_if #(.ADDR_WD(32), .DATA_WD(32)) axi ();

    dmac_write #(.ADDR_WD(32), .DATA_WD(32), .MAX_BURST_LEN(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_dst_addr  (cmd_dst_addr),
        .cmd_burst     (cmd_burst),
        .cmd_len       (cmd_len),
        .cmd_size      (cmd_size),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_in       (data_in),
        .data_in_last  (data_in_last),
        .done_valid    (done_valid),
        .done_err      (done_err),
        .m_axi         (axi.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr[$];
    int          exp_len[$];
    logic [31:0] data_mem[0:255];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // expected burst list from the splitting rules
    task automatic build_model(input logic [31:0] a, input logic [1:0] bt, input int len, input logic [2:0] sz);
        logic [31:0] ad;
        int rem;
        int b;
        int tb;
        ad  = a;
        rem = len;
        exp_addr.delete();
        exp_len.delete();
        while (rem > 0) begin
            b = (rem < 16) ? rem : 16;
            if (bt == 2'b01) begin
                tb = (4096 - int'(ad[11:0])) / (1 << sz);
                if (tb < b) b = tb;
            end
            exp_addr.push_back(ad);
            exp_len.push_back(b - 1);
            if (bt == 2'b01) ad = ad + 32'(b * (1 << sz));
            rem -= b;
        end
    endtask

    task automatic idle_inputs();
        cmd_valid     = 1'b0;
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        axi.awready   = 1'b0;
        axi.wready    = 1'b0;
        axi.bvalid    = 1'b0;
        axi.bresp     = 2'b00;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [1:0] bt, input int len, input logic [2:0] sz,
                           input int err_b, input int bad_last, input int rst_beat, input bit slow);
        int beat = 0, in_burst = 0, cur_len = 0, pend_b = 0, nb = 0, cyc = 0;
        bit cmd_done = 0, aw_open = 0, exp_err = 0, finished = 0;
        bit exp_aw = 0, exp_done = 0, stall = 0, did_rst = 0;
        logic [31:0] s_addr;
        logic [7:0]  s_len;
        build_model(a, bt, len, sz);
        for (int i = 0; i < len; i++) data_mem[i] = $urandom;
        while (!finished && !did_rst && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            cmd_valid     = !cmd_done;
            cmd_dst_addr  = a;
            cmd_burst     = bt;
            cmd_len       = 32'(len);
            cmd_size      = sz;
            axi.awready   = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            axi.wready    = slow ? ((cyc % 2) == 1) : ($urandom_range(0, 3) != 0);
            data_in_valid = (beat < len) && ($urandom_range(0, 3) != 0);
            data_in       = data_mem[beat];
            data_in_last  = (beat == len - 1) ^ (beat == bad_last);
            axi.bvalid    = ($urandom_range(0, 1) == 1);
            axi.bresp     = (pend_b > 0 && nb != err_b) ? 2'b00 : 2'b10;
            if (rst_beat >= 0 && aw_open && beat == rst_beat) begin
                rst     = 1'b1;
                did_rst = 1'b1;
            end
            #1;
            if (!did_rst) begin
                chk("cmd_ready", cmd_ready, !cmd_done);
                if (exp_aw) begin
                    chk("awvalid_next", axi.awvalid, 1);
                    exp_aw = 0;
                end
                if (exp_done) begin
                    chk("done_valid", done_valid, 1);
                    chk("done_err", done_err, exp_err);
                    finished = 1;
                end else begin
                    chk("no_done", done_valid, 0);
                end
                if (stall) begin
                    chk("aw_hold_valid", axi.awvalid, 1);
                    chk("aw_hold_addr", axi.awaddr, s_addr);
                    chk("aw_hold_len", axi.awlen, s_len);
                end
                chk("w_gate", axi.wvalid, data_in_valid && aw_open);
                chk("din_ready", data_in_ready, axi.wready && aw_open);
                chk("bready", axi.bready, pend_b > 0);
                if (axi.wvalid && axi.wready) begin
                    chk("wdata", axi.wdata, data_mem[beat]);
                    chk("wlast", axi.wlast, in_burst == cur_len - 1);
                    chk("wstrb", axi.wstrb, 4'hF);
                    if (data_in_last != (beat == len - 1)) exp_err = 1;
                    beat++;
                    in_burst++;
                    if (in_burst >= cur_len) begin
                        aw_open = 0;
                        pend_b++;
                    end
                end
                stall = 0;
                if (axi.awvalid && axi.awready) begin
                    if (exp_addr.size() == 0) begin
                        chk("aw_extra", 1, 0);
                    end else begin
                        chk("awaddr", axi.awaddr, exp_addr.pop_front());
                        cur_len = exp_len.pop_front() + 1;
                        chk("awlen", axi.awlen, cur_len - 1);
                        chk("awsize", axi.awsize, sz);
                        chk("awburst", axi.awburst, bt);
                        in_burst = 0;
                        aw_open  = 1;
                    end
                end else if (axi.awvalid) begin
                    stall  = 1;
                    s_addr = axi.awaddr;
                    s_len  = axi.awlen;
                end
                if (axi.bvalid && axi.bready) begin
                    if (axi.bresp[1]) exp_err = 1;
                    nb++;
                    pend_b--;
                    if (exp_addr.size() == 0 && beat == len) exp_done = 1;
                    else exp_aw = 1;
                end
                if (cmd_valid && cmd_ready) begin
                    cmd_done = 1;
                    exp_aw   = 1;
                end
            end
        end
        if (did_rst) begin
            @(negedge clk);
            cmd_valid     = 1'b0;
            data_in_valid = 1'b1;
            axi.bvalid    = 1'b1;
            #1;
            chk("rst_awvalid", axi.awvalid, 0);
            chk("rst_wvalid", axi.wvalid, 0);
            chk("rst_bready", axi.bready, 0);
            chk("rst_done", done_valid, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            rst = 1'b0;
            #1;
            chk("post_rst_cmd_ready", cmd_ready, 1);
        end else if (finished) begin
            @(negedge clk);
            idle_inputs();
            #1;
            chk("done_one_pulse", done_valid, 0);
            chk("cmd_ready_again", cmd_ready, 1);
        end else begin
            chk("timeout", 0, 1);
        end
        idle_inputs();
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rsz;
        idle_inputs();
        cmd_dst_addr = '0;
        cmd_burst    = '0;
        cmd_len      = '0;
        cmd_size     = '0;
        data_in      = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_awvalid", axi.awvalid, 0);
        chk("reset_wvalid", axi.wvalid, 0);
        chk("reset_bready", axi.bready, 0);
        chk("reset_done", done_valid, 0);
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);

        run_cmd(32'h0000_1000, 2'b01, 4,  3'd2, -1, -1, -1, 0);
        run_cmd(32'h0000_0000, 2'b01, 40, 3'd2, -1, -1, -1, 0);
        run_cmd(32'h0000_0FF8, 2'b01, 8,  3'd2, -1, -1, -1, 0);
        run_cmd(32'h0000_2000, 2'b00, 20, 3'd2, -1, -1, -1, 0);
        run_cmd(32'h0000_3000, 2'b01, 20, 3'd2, -1, -1, -1, 1);
        run_cmd(32'h0000_0000, 2'b01, 40, 3'd2, 1,  -1, -1, 0);
        run_cmd(32'h0000_0100, 2'b01, 10, 3'd2, -1, 5,  -1, 0);
        run_cmd(32'hFFFF_FFF0, 2'b01, 8,  3'd2, -1, -1, -1, 0);
        run_cmd(32'h0000_0FFF, 2'b01, 3,  3'd0, -1, -1, -1, 0);
        run_cmd(32'h0000_0000, 2'b01, 30, 3'd2, -1, -1, 7,  0);
        run_cmd(32'h0000_4000, 2'b01, 1,  3'd2, -1, -1, -1, 0);

        for (int n = 0; n < 30; n++) begin
            rsz = 3'($urandom_range(0, 2));
            ra  = $urandom;
            if ($urandom_range(0, 1) == 1) ra = {ra[31:12], 12'hF00 | (ra[11:0] & 12'h0FF)};
            ra  = ra & ~((32'd1 << rsz) - 32'd1);
            run_cmd(ra, ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00, $urandom_range(1, 64), rsz,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1, -1, -1,
                    $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
